data_line_fetcher: RTL and testbench

Refill engine that writes into the data cache. It takes a line-fill request from the consumer and issues one read request to the memory side. It assembles the BEATS response beats into one INW-bit line, then presents the line to the cache write port with a single-cycle `cache_write` pulse. This makes it the writer feeding the cache's `write`/`addr_in`/`data_in` inputs.

---
 rtl/data_line_fetcher.sv | 116 +++++++++++
 tb/tb_data_line_fetcher.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_line_fetcher.sv
// Cache line refill engine: accepts one fill request, issues a single memory read,
// assembles BEATS response beats into one line and strobes it into the cache.
module data_line_fetcher #(
   parameter int INW     = 512,
   parameter int ADDRW   = 32,
   parameter int BEATW   = 64,
   parameter int BEATS   = INW / BEATW,
   parameter int TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   input  logic [ADDRW-1:0] req_addr,
   output logic             req_ready,
   output logic             mem_rd_valid,
   output logic [ADDRW-1:0] mem_rd_addr,
   input  logic             mem_rd_ready,
   input  logic             mem_resp_valid,
   input  logic [BEATW-1:0] mem_resp_data,
   output logic             cache_write,
   output logic [ADDRW-1:0] cache_addr,
   output logic [INW-1:0]   cache_data,
   output logic             fill_error
);

   localparam int OFFW = $clog2(INW / 8);
   localparam int CNTW = $clog2(BEATS) + 1;
   localparam int TMOW = $clog2(TIMEOUT + 1);
   localparam logic [ADDRW-1:0] ALIGN_MASK = ~((ADDRW'(1) << OFFW) - ADDRW'(1));

   typedef enum logic [1:0] {IDLE, REQ, RECV, WRITE} state_e;

   state_e           state_q, state_d;
   logic [ADDRW-1:0] addr_q, addr_d;
   logic [ADDRW-1:0] caddr_q, caddr_d;
   logic [INW-1:0]   data_q, data_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [TMOW-1:0]  tmo_q, tmo_d;
   logic             err_q, err_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      caddr_d = caddr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr & ALIGN_MASK;
               state_d = REQ;
            end
         end
         REQ: begin
            if (mem_rd_ready) begin
               cnt_d   = '0;
               tmo_d   = '0;
               state_d = RECV;
            end
         end
         RECV: begin
            if (mem_resp_valid) begin
               // Beats land directly in the output register; beat 0 is the LSBs.
               for (int b = 0; b < BEATS; b++) begin
                  if (cnt_q == CNTW'(b)) data_d[b*BEATW +: BEATW] = mem_resp_data;
               end
               cnt_d = cnt_q + CNTW'(1);
               tmo_d = '0;
               if (cnt_q == CNTW'(BEATS - 1)) begin
                  caddr_d = addr_q;
                  state_d = WRITE;
               end
            end else begin
               tmo_d = tmo_q + TMOW'(1);
               if (tmo_q == TMOW'(TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WRITE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         caddr_q <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         caddr_q <= caddr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign mem_rd_valid = (state_q == REQ);
   assign mem_rd_addr  = addr_q;
   assign cache_write  = (state_q == WRITE);
   assign cache_addr   = caddr_q;
   assign cache_data   = data_q;
   assign fill_error   = err_q;

endmodule

// File: tb/tb_data_line_fetcher.sv
// Scoreboard bench for data_line_fetcher: expected lines are queued as fills are
// driven and checked whenever the DUT strobes cache_write.
module tb_data_line_fetcher;
   localparam int INW = 512, ADDRW = 32, BEATW = 64, BEATS = 8, TMO = 4;

   logic             clk = 1'b0, rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic [ADDRW-1:0] req_addr = '0;
   logic             req_ready, mem_rd_valid;
   logic [ADDRW-1:0] mem_rd_addr;
   logic             mem_rd_ready = 1'b0, mem_resp_valid = 1'b0;
   logic [BEATW-1:0] mem_resp_data = '0;
   logic             cache_write, fill_error;
   logic [ADDRW-1:0] cache_addr;
   logic [INW-1:0]   cache_data;

   data_line_fetcher #(.INW(INW), .ADDRW(ADDRW), .BEATW(BEATW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .cache_write(cache_write), .cache_addr(cache_addr), .cache_data(cache_data),
      .fill_error(fill_error)
   );

   always #5 clk = ~clk;

   typedef struct { logic [ADDRW-1:0] addr; logic [INW-1:0] data; } exp_t;
   exp_t sb[$];
   exp_t mon_e;
   int total = 0, bad = 0, wr_cnt = 0, err_cnt = 0;

   // Scoreboard checker: every cache_write must match the oldest queued line.
   always @(negedge clk) begin
      if (rst_n) begin
         if (fill_error === 1'b1) err_cnt++;
         if (cache_write === 1'b1) begin
            wr_cnt++;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_write: got addr=%h, want no write", cache_addr);
            end else begin
               mon_e = sb.pop_front();
               if (cache_addr !== mon_e.addr || cache_data !== mon_e.data) begin
                  bad++;
                  $display("FAIL line_write: got addr=%h data=%h want addr=%h data=%h",
                           cache_addr, cache_data, mon_e.addr, mon_e.data);
               end
            end
         end
      end
   end

   task automatic run_fill(input logic [31:0] addr, input logic [63:0] tag, input int stall,
                           input int gap, input bit skip_req, input bit hold_next,
                           input logic [31:0] next_addr, input int exp_wc, input string nm);
      int cyc, wc;
      logic [INW-1:0] line;
      exp_t e;
      for (int b = 0; b < BEATS; b++) line[b*BEATW +: BEATW] = tag | 64'(b);
      e.addr = addr & 32'hFFFF_FFC0;
      e.data = line;
      sb.push_back(e);
      if (!skip_req) begin
         @(negedge clk);
         total++;
         if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_idle: got req_ready=%b want 1", nm, req_ready);
         end
         req_valid = 1'b1;
         req_addr  = addr;
      end
      cyc = 0;
      for (int s = 0; s <= stall; s++) begin
         @(negedge clk); cyc++;
         req_valid = 1'b0;
         req_addr  = $urandom;
         total++;
         if (mem_rd_valid !== 1'b1 || mem_rd_addr !== e.addr || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_req_phase: cyc=%0d got valid=%b addr=%h ready=%b want 1 %h 0",
                     nm, cyc, mem_rd_valid, mem_rd_addr, req_ready, e.addr);
         end
         mem_rd_ready   = (s == stall);
         mem_resp_valid = 1'b1;
         mem_resp_data  = {$urandom, $urandom};
      end
      for (int b = 0; b < BEATS; b++) begin
         @(negedge clk); cyc++;
         mem_rd_ready = 1'b0;
         total++;
         if (mem_rd_valid !== 1'b0 || cache_write !== 1'b0 || req_ready !== 1'b0 || fill_error !== 1'b0) begin
            bad++;
            $display("FAIL %s_recv: beat=%0d got valid=%b wr=%b ready=%b err=%b want 0 0 0 0",
                     nm, b, mem_rd_valid, cache_write, req_ready, fill_error);
         end
         if (hold_next) begin
            req_valid = 1'b1;
            req_addr  = next_addr;
         end
         mem_resp_valid = 1'b1;
         mem_resp_data  = line[b*BEATW +: BEATW];
         if (b < BEATS - 1) begin
            for (int g = 0; g < gap; g++) begin
               @(negedge clk); cyc++;
               mem_resp_valid = 1'b0;
               mem_resp_data  = {$urandom, $urandom};
            end
         end
      end
      wc = -1;
      for (int t = 0; t < 6 && wc < 0; t++) begin
         @(negedge clk); cyc++;
         mem_resp_valid = 1'b0;
         if (cache_write === 1'b1) wc = cyc;
      end
      total++;
      if (wc != exp_wc) begin
         bad++;
         $display("FAIL %s_write_cycle: got %0d want %0d", nm, wc, exp_wc);
      end
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1 || cache_write !== 1'b0) begin
         bad++;
         $display("FAIL %s_after_write: got ready=%b wr=%b want 1 0", nm, req_ready, cache_write);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if (req_ready !== 1'b1 || mem_rd_valid !== 1'b0 || cache_write !== 1'b0 || fill_error !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got ready=%b rdv=%b wr=%b err=%b want 1 0 0 0",
                  req_ready, mem_rd_valid, cache_write, fill_error);
      end
      total++;
      if (mem_rd_addr !== '0 || cache_addr !== '0) begin
         bad++;
         $display("FAIL reset_addr: got rd=%h ca=%h want 0 0", mem_rd_addr, cache_addr);
      end
      total++;
      if (cache_data !== '0) begin
         bad++;
         $display("FAIL reset_data: got %h want 0", cache_data);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_timeout();
      int wr0, err0;
      wr0 = wr_cnt; err0 = err_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0000_5555;
      @(negedge clk);
      req_valid = 1'b0; mem_rd_ready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         mem_rd_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = {$urandom, $urandom};
      end
      for (int k = 0; k < TMO; k++) begin
         @(negedge clk);
         mem_resp_valid = 1'b0;
         total++;
         if (fill_error !== 1'b0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL timeout_wait: idle=%0d got err=%b ready=%b want 0 0", k, fill_error, req_ready);
         end
      end
      @(negedge clk);
      total++;
      if (fill_error !== 1'b1 || req_ready !== 1'b1 || cache_write !== 1'b0) begin
         bad++;
         $display("FAIL timeout_abort: got err=%b ready=%b wr=%b want 1 1 0", fill_error, req_ready, cache_write);
      end
      @(negedge clk);
      total++;
      if (fill_error !== 1'b0 || wr_cnt != wr0 || err_cnt != err0 + 1) begin
         bad++;
         $display("FAIL timeout_pulse: got err=%b writes=%0d errs=%0d want 0 %0d %0d",
                  fill_error, wr_cnt, err_cnt, wr0, err0 + 1);
      end
   endtask

   task automatic test_reset_mid();
      int wr0, err0;
      wr0 = wr_cnt; err0 = err_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0001_0040;
      @(negedge clk);
      req_valid = 1'b0; mem_rd_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         mem_rd_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = {$urandom, $urandom};
      end
      @(negedge clk);
      mem_resp_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      total++;
      if (req_ready !== 1'b1 || mem_rd_valid !== 1'b0 || cache_write !== 1'b0 || fill_error !== 1'b0 ||
          mem_rd_addr !== '0 || cache_addr !== '0 || cache_data !== '0) begin
         bad++;
         $display("FAIL reset_mid: got ready=%b rdv=%b wr=%b err=%b rd=%h ca=%h want 1 0 0 0 0 0 data 0",
                  req_ready, mem_rd_valid, cache_write, fill_error, mem_rd_addr, cache_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (wr_cnt != wr0 || err_cnt != err0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_quiet: got writes=%0d errs=%0d ready=%b want %0d %0d 1",
                  wr_cnt, err_cnt, req_ready, wr0, err0);
      end
   endtask

   task automatic test_basic();
      run_fill(32'h0000_1234, 64'h0, 0, 0, 1'b0, 1'b0, '0, 10, "basic");
   endtask

   task automatic test_backpressure();
      run_fill(32'h00AB_CDEF, 64'hBEEF_0000_0000_0000, 5, 0, 1'b0, 1'b0, '0, 15, "backpressure");
   endtask

   task automatic test_gapped();
      run_fill(32'h7FFF_FFC1, 64'h1111_2222_3333_4400, 0, 3, 1'b0, 1'b0, '0, 31, "gapped");
   endtask

   task automatic test_back_to_back();
      run_fill(32'h0000_8A7C, 64'hAAAA_0000_5555_0000, 0, 0, 1'b0, 1'b1, 32'h0004_0FFF, 10, "busy_first");
      run_fill(32'h0004_0FFF, 64'h0123_4567_89AB_CD00, 0, 0, 1'b1, 1'b0, '0, 10, "busy_second");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_gapped();
      test_timeout();
      run_fill(32'h0000_3000, 64'hCAFE_0000_0000_0000, 0, 0, 1'b0, 1'b0, '0, 10, "after_timeout");
      test_reset_mid();
      run_fill(32'h0001_0040, 64'hD00D_0000_0000_0000, 0, 0, 1'b0, 1'b0, '0, 10, "after_reset");
      test_back_to_back();
      repeat (2) @(negedge clk);
      total++;
      if (wr_cnt != 7 || err_cnt != 1 || sb.size() != 0) begin
         bad++;
         $display("FAIL totals: got writes=%0d errs=%0d pending=%0d want 7 1 0", wr_cnt, err_cnt, sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
